// File: rtl/psmac_pkg.sv
// Shared constants for the bit-serial multiply-accumulate block.
package psmac_pkg;

  localparam int unsigned W_DEF  = 4;
  localparam int unsigned AW_DEF = 12;

  // Sequencer state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_ACC  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/psmac_seq_fa_cell.sv
// 1-bit full adder assembled from two half-adder cells.

module ha_cell (
  input  logic i_a,
  input  logic i_b,
  output logic o_s,
  output logic o_c
);

  assign o_s = i_a ^ i_b;
  assign o_c = i_a & i_b;

endmodule

module fa_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);

  logic w_s0;
  logic w_c0;
  logic w_c1;

  ha_cell u_ha0 (
    .i_a (i_a),
    .i_b (i_b),
    .o_s (w_s0),
    .o_c (w_c0)
  );

  ha_cell u_ha1 (
    .i_a (w_s0),
    .i_b (i_c),
    .o_s (o_s),
    .o_c (w_c1)
  );

  assign o_c = w_c0 | w_c1;

endmodule

// File: rtl/psmac_seq.sv
// Bit-serial multiply-accumulate: acc <= (acc + a*b) mod 2^AW through a
// single shared full-adder cell. AW must be at least 2*W.

module psmac_seq
  import psmac_pkg::*;
#(
  parameter int unsigned W  = W_DEF,
  parameter int unsigned AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          clr,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  output logic          ready,
  output logic          done,
  output logic [AW-1:0] acc,
  output logic          ovf
);

  localparam int unsigned BIT_W  = $clog2(AW);
  localparam int unsigned PASS_W = (W > 1) ? $clog2(W) : 1;

  localparam logic [BIT_W-1:0]  BIT_LAST_MUL = BIT_W'(2 * W - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST_ACC = BIT_W'(AW - 1);
  localparam logic [PASS_W-1:0] PASS_LAST    = PASS_W'(W - 1);

  logic [1:0]        r_state;
  logic [W-1:0]      r_a;
  logic [W-1:0]      r_b;
  logic [AW-1:0]     r_pp;
  logic [AW-1:0]     r_sum;
  logic [AW-1:0]     r_acc;
  logic              r_ovf;
  logic              r_carry;
  logic              r_fin;
  logic [BIT_W-1:0]  r_bit;
  logic [PASS_W-1:0] r_pass;

  logic [AW-1:0]     w_mul_addend;
  logic              w_fa_x;
  logic              w_fa_y;
  logic              w_fa_s;
  logic              w_fa_c;

  // Shifted multiplicand for the current pass, gated by the multiplier bit
  always_comb begin
    w_mul_addend = '0;
    if (r_b[r_pass]) begin
      w_mul_addend = {{(AW - W){1'b0}}, r_a} << r_pass;
    end
  end

  // Operand routing into the shared full adder
  always_comb begin
    w_fa_x = 1'b0;
    w_fa_y = 1'b0;
    case (r_state)
      ST_MUL: begin
        w_fa_x = r_pp[r_bit];
        w_fa_y = w_mul_addend[r_bit];
      end
      ST_ACC: begin
        w_fa_x = r_acc[r_bit];
        w_fa_y = r_pp[r_bit];
      end
      default: begin
        w_fa_x = 1'b0;
        w_fa_y = 1'b0;
      end
    endcase
  end

  fa_cell u_fa (
    .i_a (w_fa_x),
    .i_b (w_fa_y),
    .i_c (r_carry),
    .o_s (w_fa_s),
    .o_c (w_fa_c)
  );

  // Sequencer and datapath registers.
  // The ACC sum lands in r_sum so acc stays stable while busy; one extra
  // cycle (r_fin) then commits r_sum and the final carry-out into acc/ovf.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_pp    <= '0;
      r_sum   <= '0;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
      r_carry <= 1'b0;
      r_fin   <= 1'b0;
      r_bit   <= '0;
      r_pass  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (clr) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
          end
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_pp    <= '0;
            r_carry <= 1'b0;
            r_fin   <= 1'b0;
            r_bit   <= '0;
            r_pass  <= '0;
            r_state <= ST_MUL;
          end
        end
        ST_MUL: begin
          r_pp[r_bit] <= w_fa_s;
          if (r_bit == BIT_LAST_MUL) begin
            r_bit   <= '0;
            r_carry <= 1'b0;
            if (r_pass == PASS_LAST) begin
              r_pass  <= '0;
              r_state <= ST_ACC;
            end else begin
              r_pass <= r_pass + PASS_W'(1);
            end
          end else begin
            r_bit   <= r_bit + BIT_W'(1);
            r_carry <= w_fa_c;
          end
        end
        ST_ACC: begin
          if (r_fin) begin
            r_acc   <= r_sum;
            r_ovf   <= r_ovf | r_carry;
            r_carry <= 1'b0;
            r_fin   <= 1'b0;
            r_state <= ST_DONE;
          end else begin
            r_sum[r_bit] <= w_fa_s;
            r_carry      <= w_fa_c;
            if (r_bit == BIT_LAST_ACC) begin
              r_bit <= '0;
              r_fin <= 1'b1;
            end else begin
              r_bit <= r_bit + BIT_W'(1);
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ready = (r_state == ST_IDLE);
  assign done  = (r_state == ST_DONE);
  assign acc   = r_acc;
  assign ovf   = r_ovf;

endmodule

// File: tb/tb_psmac_seq.sv
// Self-checking bench for psmac_seq against an arithmetic MAC reference.

module tb_psmac_seq;

  localparam int unsigned W   = 4;
  localparam int unsigned AW  = 12;
  localparam int unsigned LAT = 2 * W * W + AW + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          clr;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          ready;
  logic          done;
  logic [AW-1:0] acc;
  logic          ovf;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  // Reference state: plain integer accumulator and sticky overflow
  int unsigned m_acc = 0;
  bit          m_ovf = 1'b0;

  psmac_seq #(.W(W), .AW(AW)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .clr   (clr),
    .a     (a),
    .b     (b),
    .ready (ready),
    .done  (done),
    .acc   (acc),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_mac(input int unsigned ta, input int unsigned tb_);
    int unsigned s;
    s = m_acc + ta * tb_;
    if (s >= (1 << AW)) m_ovf = 1'b1;
    m_acc = s % (1 << AW);
  endtask

  task automatic clr_op();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    m_acc = 0;
    m_ovf = 1'b0;
    check("clr_acc", 32'(acc), 32'(m_acc));
    check("clr_ovf", 32'(ovf), 32'(m_ovf));
  endtask

  // Issue one operation from IDLE and follow it to completion.
  task automatic run_op(input int unsigned ta, input int unsigned tb_,
                        input bit with_clr, input bit spam, input string tag);
    int unsigned n;
    int unsigned busy_bad;
    int unsigned acc_moved;
    int unsigned held;
    n         = 0;
    busy_bad  = 0;
    acc_moved = 0;
    start = 1'b1;
    clr   = with_clr;
    a     = W'(ta);
    b     = W'(tb_);
    tick();
    if (with_clr) begin
      m_acc = 0;
      m_ovf = 1'b0;
    end
    held = m_acc;
    model_mac(ta, tb_);
    start = 1'b0;
    clr   = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    while (done !== 1'b1 && n < LAT + 20) begin
      if (ready !== 1'b0) busy_bad++;
      if (acc !== AW'(held)) acc_moved++;
      if (spam) begin
        start = 1'($urandom);
        clr   = 1'($urandom);
        a     = W'(9);
        b     = W'(9);
      end
      tick();
      n++;
    end
    start = 1'b0;
    clr   = 1'b0;
    check({tag, "_latency"}, n, LAT);
    check({tag, "_busy_ready"}, busy_bad, 0);
    check({tag, "_acc_stable"}, acc_moved, 0);
    check({tag, "_acc"}, 32'(acc), 32'(m_acc));
    check({tag, "_ovf"}, 32'(ovf), 32'(m_ovf));
    check({tag, "_ready_in_done"}, 32'(ready), 0);
    tick();
    check({tag, "_done_pulse"}, 32'(done), 0);
    check({tag, "_ready_after"}, 32'(ready), 1);
  endtask

  initial begin
    int unsigned dones;
    rst   = 1'b1;
    start = 1'b0;
    clr   = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) tick();
    check("rst_ready", 32'(ready), 1);
    check("rst_done", 32'(done), 0);
    check("rst_acc", 32'(acc), 0);
    check("rst_ovf", 32'(ovf), 0);
    rst = 1'b0;
    tick();

    clr_op();
    run_op(3, 5, 1'b0, 1'b0, "a3b5");
    check("a3b5_abs", 32'(acc), 15);
    run_op(15, 15, 1'b0, 1'b0, "a15b15");
    check("a15b15_abs", 32'(acc), 240);
    run_op(0, 13, 1'b0, 1'b0, "a0");
    run_op(6, 0, 1'b0, 1'b0, "b0");
    check("zero_ops_abs", 32'(acc), 240);
    run_op(7, 9, 1'b1, 1'b0, "clr_start");
    check("clr_start_abs", 32'(acc), 63);

    clr_op();
    repeat (17) run_op(15, 15, 1'b0, 1'b0, "sat");
    check("op17_acc", 32'(acc), 3825);
    check("op17_ovf", 32'(ovf), 0);
    run_op(15, 15, 1'b0, 1'b0, "op18");
    check("op18_acc", 32'(acc), 4050);
    check("op18_ovf", 32'(ovf), 0);
    run_op(15, 15, 1'b0, 1'b0, "op19");
    check("op19_acc", 32'(acc), 179);
    check("op19_ovf", 32'(ovf), 1);
    run_op(2, 3, 1'b0, 1'b0, "sticky");
    check("sticky_ovf", 32'(ovf), 1);
    clr_op();

    run_op(9, 9, 1'b0, 1'b1, "spam");
    dones = 0;
    repeat (8) begin
      if (done === 1'b1) dones++;
      tick();
    end
    check("spam_extra_done", dones, 0);
    check("spam_acc_hold", 32'(acc), 32'(m_acc));

    for (int i = 0; i < 10; i++) begin
      int unsigned ra;
      int unsigned rb;
      bit rc;
      ra = $urandom_range(0, 15);
      rb = $urandom_range(0, 15);
      rc = ($urandom_range(0, 3) == 0);
      run_op(ra, rb, rc, 1'b0, "rand");
    end

    // Abort an operation with reset at the 20th edge after accept
    start = 1'b1;
    a     = W'(9);
    b     = W'(9);
    tick();
    start = 1'b0;
    dones = 0;
    for (int i = 1; i < 20; i++) begin
      if (done === 1'b1) dones++;
      tick();
    end
    rst = 1'b1;
    tick();
    m_acc = 0;
    m_ovf = 1'b0;
    check("abort_ready", 32'(ready), 1);
    check("abort_acc", 32'(acc), 32'(m_acc));
    check("abort_ovf", 32'(ovf), 32'(m_ovf));
    check("abort_done", 32'(done), 0);
    rst = 1'b0;
    repeat (LAT + 10) begin
      if (done === 1'b1) dones++;
      tick();
    end
    check("abort_no_done", dones, 0);
    check("abort_idle_ready", 32'(ready), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
